dot_tracker: RTL and testbench
==============================

// Module: dot_tracker
// PURPOSE
//  Owns the pellet map: the game side writes it once per frame, the video side
//  reads it once per pixel. Game side: samples the Pacman position on each frame
//  edge, clears the pellet under it, and counts score and pellets remaining.
//  Video side: answers "pellet pixel here?" for every DrawX/DrawY from color_mapper.
//  Sits between the pacman sprite logic, color_mapper and the HEX score path.
// PARAMETERS
//  GRID_W    42   cells per row
//  GRID_H    42   rows
//  CELL_SH   3    log2 of cell size in pixels (8)
//  ORIGIN_X  56   pixel X of cell column 0
//  ORIGIN_Y  56   pixel Y of cell row 0
//  SCORE_W   11   width of score and dots_left (must hold GRID_W*GRID_H)
// PORTS
//  Clk          in   1        50 MHz system clock; all state is in this domain
//  Reset_h      in   1        reset, asynchronous, active-high
//  frame_clk    in   1        VGA_VS; asynchronous to Clk and is synchronised inside
//  pacmanX      in   10       Pacman pixel X, stable around frame_clk rising edge
//  pacmanY      in   10       Pacman pixel Y
//  DrawX        in   10       current video pixel X
//  DrawY        in   10       current video pixel Y
//  dot_on       out  1        pellet pixel at (DrawX,DrawY); 2-Clk latency
//  score        out  SCORE_W  number of pellets eaten
//  dots_left    out  SCORE_W  number of pellets remaining
//  eat_pulse    out  1        1-Clk strobe for each pellet eaten
//  level_clear  out  1        sticky high when dots_left==0
//  busy         out  1        high during CLEAR and the eat sequence
// BEHAVIOUR
//  Storage: GRID_H words of GRID_W bits. Port A is read-modify-write (game side).
//   Port B is read-only (video side). 1 = pellet present.
//  Reset (async): state<=CLEAR, row_ctr<=0, score<=0, dots_left<=GRID_W*GRID_H,
//   eat_pulse<=0, level_clear<=0, dot_on<=0, busy<=1, sync flops<=0.
//  FSM states and transitions:
//   CLEAR: writes all-ones to row row_ctr, one row per Clk; after row GRID_H-1,
//    goes to IDLE (GRID_H cycles). dot_on is forced to 0 and frame edges are ignored.
//   IDLE: on frame_pulse with pacman in grid, latch col=(pacmanX-ORIGIN_X)>>CELL_SH
//    and row=(pacmanY-ORIGIN_Y)>>CELL_SH, then go to RD. Otherwise stay in IDLE.
//   RD: issue port-A read of row, then go to CHK.
//   CHK: if bit[col]==1, go to WR; else go to IDLE with no change.
//   WR: write row with bit[col]=0, score+=1, dots_left-=1, eat_pulse=1, then go to IDLE.
//  frame_pulse: 2-FF synchroniser on frame_clk plus rising-edge detect, giving
//   1 Clk. A pulse that arrives while not in IDLE is dropped.
//  In-grid test is inclusive on both ends: ORIGIN_X <= pacmanX <=
//   ORIGIN_X+GRID_W*8-1 (391), and the same for Y (391). Out-of-grid is a no-op.
//  score and dots_left change only in WR, so they can never overflow or
//   underflow. level_clear sets on the cycle after dots_left reaches 0.
//  busy = (state != IDLE).
//  Video path:
//   Stage 1 registers vrow, vcol, in-grid flag, and the pixel offset within the
//    cell, then reads port B.
//   Stage 2 computes dot_on = bit[vcol] & ingrid & offX in {3,4} & offY in {3,4}.
//    The pellet is 2x2 pixels centred in its cell.
//  Write bypass: if port-A WR and port-B read hit the same row in the same cycle,
//   port B returns the post-write data.
//  Reset mid-sequence (RD/CHK/WR): the pending eat is abandoned and the FSM
//   re-enters CLEAR. No partial score update remains.
// TESTING
//  T1 Reset then release -> busy high for 42 Clk. Then score=0, dots_left=1764,
//     and DrawX=59,DrawY=59 gives dot_on=1 two Clk later.
//  T2 pacman=(60,60), frame edge -> within 8 Clk: eat_pulse for 1 cycle, score=1,
//     dots_left=1763. Draw(59,59) gives dot_on=0; Draw(67,59) gives dot_on=1.
//  T3 Same position on the next frame -> no eat_pulse, score stays 1.
//  T4 pacman=(391,391) eats cell (41,41). pacman=(392,60) and (55,60) -> no change.
//  T5 Reset_h asserted in WR state -> score=0, dots_left=1764, map refilled after 42 Clk.
//  T6 Visit all 1764 cells -> score=1764, dots_left=0, level_clear=1.
//     Further frames make no change. Bypass: Draw row == written row in WR -> dot_on=0.

Source files
------------

// File: rtl/dot_tracker.sv
`timescale 1ns/1ps
// Pellet map for the maze: the game side clears the pellet under Pacman once per frame
// and keeps score, while the video side looks up pellet pixels with two Clk of latency.
//
// state   | meaning
// CLEAR   | refill one map row per Clk with pellets; frame edges ignored, dot_on held 0
// IDLE    | wait for a frame edge with Pacman inside the grid
// RD      | read the row under Pacman
// CHK     | pellet present? eat it, otherwise back to IDLE
// WR      | write the row back without the pellet, bump score, pulse eat_pulse
module dot_tracker #(
   parameter int GRID_W   = 42,
   parameter int GRID_H   = 42,
   parameter int CELL_SH  = 3,
   parameter int ORIGIN_X = 56,
   parameter int ORIGIN_Y = 56,
   parameter int SCORE_W  = 11
) (
   input  logic               Clk,
   input  logic               Reset_h,
   input  logic               frame_clk,
   input  logic [9:0]         pacmanX,
   input  logic [9:0]         pacmanY,
   input  logic [9:0]         DrawX,
   input  logic [9:0]         DrawY,
   output logic               dot_on,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] dots_left,
   output logic               eat_pulse,
   output logic               level_clear,
   output logic               busy
);

   localparam int RW      = $clog2(GRID_H);
   localparam int CW      = $clog2(GRID_W);
   localparam int CELL_PX = 1 << CELL_SH;

   localparam logic [9:0]         X_LO     = 10'(ORIGIN_X);
   localparam logic [9:0]         X_HI     = 10'(ORIGIN_X + GRID_W * CELL_PX - 1);
   localparam logic [9:0]         Y_LO     = 10'(ORIGIN_Y);
   localparam logic [9:0]         Y_HI     = 10'(ORIGIN_Y + GRID_H * CELL_PX - 1);
   localparam logic [RW-1:0]      LAST_ROW = RW'(GRID_H - 1);
   localparam logic [SCORE_W-1:0] TOTAL    = SCORE_W'(GRID_W * GRID_H);
   localparam logic [CELL_SH-1:0] PEL_LO   = CELL_SH'(CELL_PX / 2 - 1);
   localparam logic [CELL_SH-1:0] PEL_HI   = CELL_SH'(CELL_PX / 2);

   typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_RD, S_CHK, S_WR} state_t;

   state_t              state;
   logic [GRID_W-1:0]   map_mem [GRID_H];
   logic [RW-1:0]       row_ctr;
   logic [RW-1:0]       row_q;
   logic [CW-1:0]       col_q;
   logic [GRID_W-1:0]   rd_q;
   logic [GRID_W-1:0]   wr_row;

   logic                fs1, fs2, fs3;
   logic                frame_pulse;
   logic                pac_in;
   logic [RW-1:0]       pac_row;
   logic [CW-1:0]       pac_col;

   logic                vin_d;
   logic                vin;
   logic [RW-1:0]       vrow;
   logic [CW-1:0]       vcol;
   logic [CELL_SH-1:0]  voff_x, voff_y;
   logic [GRID_W-1:0]   vword;

   always_ff @(posedge Clk or posedge Reset_h) begin
      if (Reset_h) begin
         fs1 <= 1'b0;
         fs2 <= 1'b0;
         fs3 <= 1'b0;
      end else begin
         fs1 <= frame_clk;
         fs2 <= fs1;
         fs3 <= fs2;
      end
   end

   assign frame_pulse = fs2 & ~fs3;

   assign pac_in  = (pacmanX >= X_LO) && (pacmanX <= X_HI) &&
                    (pacmanY >= Y_LO) && (pacmanY <= Y_HI);
   assign pac_col = CW'((pacmanX - X_LO) >> CELL_SH);
   assign pac_row = RW'((pacmanY - Y_LO) >> CELL_SH);

   always_comb begin
      wr_row        = rd_q;
      wr_row[col_q] = 1'b0;
   end

   always_ff @(posedge Clk or posedge Reset_h) begin
      if (Reset_h) begin
         state       <= S_CLEAR;
         row_ctr     <= '0;
         row_q       <= '0;
         col_q       <= '0;
         rd_q        <= '0;
         score       <= '0;
         dots_left   <= TOTAL;
         eat_pulse   <= 1'b0;
         level_clear <= 1'b0;
         busy        <= 1'b1;
      end else begin
         eat_pulse <= 1'b0;
         if (dots_left == '0)
            level_clear <= 1'b1;
         case (state)
            S_CLEAR: begin
               busy <= 1'b1;
               if (row_ctr == LAST_ROW) begin
                  row_ctr <= '0;
                  state   <= S_IDLE;
                  busy    <= 1'b0;
               end else begin
                  row_ctr <= row_ctr + 1'b1;
               end
            end
            S_IDLE: begin
               if (frame_pulse && pac_in) begin
                  row_q <= pac_row;
                  col_q <= pac_col;
                  state <= S_RD;
                  busy  <= 1'b1;
               end
            end
            S_RD: begin
               rd_q  <= map_mem[row_q];
               state <= S_CHK;
            end
            S_CHK: begin
               if (rd_q[col_q]) begin
                  state <= S_WR;
               end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            S_WR: begin
               score     <= score + 1'b1;
               dots_left <= dots_left - 1'b1;
               eat_pulse <= 1'b1;
               state     <= S_IDLE;
               busy      <= 1'b0;
            end
            default: begin
               state <= S_CLEAR;
               busy  <= 1'b1;
            end
         endcase
      end
   end

   // Map storage has no reset: CLEAR rebuilds it row by row after every reset.
   always_ff @(posedge Clk) begin
      if (state == S_CLEAR)
         map_mem[row_ctr] <= '1;
      else if (state == S_WR)
         map_mem[row_q] <= wr_row;
   end

   assign vin_d = (DrawX >= X_LO) && (DrawX <= X_HI) &&
                  (DrawY >= Y_LO) && (DrawY <= Y_HI);

   // Row/col are zeroed outside the grid so the lookup never indexes past the map.
   always_ff @(posedge Clk or posedge Reset_h) begin
      if (Reset_h) begin
         vin    <= 1'b0;
         vrow   <= '0;
         vcol   <= '0;
         voff_x <= '0;
         voff_y <= '0;
      end else begin
         vin    <= vin_d;
         vrow   <= vin_d ? RW'((DrawY - Y_LO) >> CELL_SH) : '0;
         vcol   <= vin_d ? CW'((DrawX - X_LO) >> CELL_SH) : '0;
         voff_x <= CELL_SH'(DrawX - X_LO);
         voff_y <= CELL_SH'(DrawY - Y_LO);
      end
   end

   // Video read sees the row as it will be after a same-cycle eat write.
   always_comb begin
      vword = map_mem[vrow];
      if (state == S_WR && row_q == vrow)
         vword = wr_row;
   end

   always_ff @(posedge Clk or posedge Reset_h) begin
      if (Reset_h)
         dot_on <= 1'b0;
      else
         dot_on <= (state != S_CLEAR) && vin && vword[vcol] &&
                   (voff_x == PEL_LO || voff_x == PEL_HI) &&
                   (voff_y == PEL_LO || voff_y == PEL_HI);
   end

endmodule

// File: tb/tb_dot_tracker.sv
`timescale 1ns/1ps
// Randomised bench for dot_tracker: a pellet-grid model predicts each frame's outcome and
// each pixel's dot_on; a negedge monitor pops the expectations when the DUT responds.
module tb_dot_tracker;

   localparam int GW    = 42;
   localparam int GH    = 42;
   localparam int TOTAL = GW * GH;
   localparam int OX    = 56;
   localparam int OY    = 56;
   localparam int XMAX  = OX + GW * 8 - 1;
   localparam int YMAX  = OY + GH * 8 - 1;

   logic        Clk = 1'b0;
   logic        Reset_h = 1'b1;
   logic        frame_clk = 1'b0;
   logic [9:0]  pacmanX = '0, pacmanY = '0, DrawX = '0, DrawY = '0;
   logic        dot_on, eat_pulse, level_clear, busy;
   logic [10:0] score, dots_left;

   always #5 Clk = ~Clk;

   dot_tracker dut (
      .Clk(Clk), .Reset_h(Reset_h), .frame_clk(frame_clk),
      .pacmanX(pacmanX), .pacmanY(pacmanY), .DrawX(DrawX), .DrawY(DrawY),
      .dot_on(dot_on), .score(score), .dots_left(dots_left),
      .eat_pulse(eat_pulse), .level_clear(level_clear), .busy(busy)
   );

   typedef struct {
      int eat;
      int score;
      int dots;
      int bcyc;
   } gexp_t;

   int    n_tests = 0;
   int    n_fail  = 0;
   bit    model_map [GH][GW];
   int    m_score, m_dots;
   gexp_t gq[$];
   bit    vq[$];
   bit    vreq = 1'b0;
   bit    d1 = 1'b0, d2 = 1'b0;
   int    bc = 0, ec = 0;
   logic  bprev = 1'b1;

   task automatic chk(string name, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   function automatic bit in_grid(int x, int y);
      return (x >= OX) && (x <= XMAX) && (y >= OY) && (y <= YMAX);
   endfunction

   function automatic bit model_dot(int x, int y);
      int ox, oy;
      if (!in_grid(x, y)) return 1'b0;
      ox = (x - OX) % 8;
      oy = (y - OY) % 8;
      if (!(ox == 3 || ox == 4) || !(oy == 3 || oy == 4)) return 1'b0;
      return model_map[(y - OY) / 8][(x - OX) / 8];
   endfunction

   // Monitor: video results two Clk after each draw, game results on each busy fall.
   always @(negedge Clk) begin
      if (Reset_h) begin
         bc = 0;
         ec = 0;
         d1 = 1'b0;
         d2 = 1'b0;
         bprev = 1'b1;
      end else begin
         if (d2) begin
            if (vq.size() == 0) fail_now("dot_on_unexpected_result");
            else chk("dot_on", int'(dot_on), int'(vq.pop_front()));
         end
         d2 = d1;
         d1 = vreq;
         if (busy) bc++;
         if (eat_pulse) ec++;
         if (bprev && !busy) begin
            if (gq.size() == 0) begin
               fail_now("busy_fall_without_request");
            end else begin
               gexp_t e;
               e = gq.pop_front();
               chk("eat_pulse_cycles", ec, e.eat);
               chk("score", int'(score), e.score);
               chk("dots_left", int'(dots_left), e.dots);
               chk("busy_cycles", bc, e.bcyc);
            end
            bc = 0;
            ec = 0;
         end
         bprev = busy;
      end
   end

   task automatic cycles(int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic vdraw(int x, int y, bit e);
      DrawX = 10'(x);
      DrawY = 10'(y);
      vq.push_back(e);
      vreq = 1'b1;
      cycles(1);
      vreq = 1'b0;
   endtask

   task automatic vdraw_m(int x, int y);
      vdraw(x, y, model_dot(x, y));
   endtask

   task automatic wait_gq(int lim, string name);
      int k = 0;
      while (gq.size() != 0 && k < lim) begin
         cycles(1);
         k++;
      end
      if (gq.size() != 0) begin
         fail_now({name, "_timeout"});
         gq.delete();
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < GH; r++)
         for (int c = 0; c < GW; c++)
            model_map[r][c] = 1'b1;
      m_score = 0;
      m_dots  = TOTAL;
   endtask

   task automatic do_reset();
      gexp_t e;
      Reset_h   = 1'b1;
      frame_clk = 1'b0;
      vreq      = 1'b0;
      gq.delete();
      vq.delete();
      model_reset();
      e.eat = 0; e.score = 0; e.dots = TOTAL; e.bcyc = GH;
      gq.push_back(e);
      cycles(3);
      Reset_h = 1'b0;
   endtask

   task automatic frame(int x, int y);
      bit in_g = in_grid(x, y);
      pacmanX = 10'(x);
      pacmanY = 10'(y);
      if (in_g) begin
         gexp_t e;
         int r = (y - OY) / 8;
         int c = (x - OX) / 8;
         e.eat = model_map[r][c] ? 1 : 0;
         if (e.eat == 1) begin
            model_map[r][c] = 1'b0;
            m_score++;
            m_dots--;
         end
         e.score = m_score;
         e.dots  = m_dots;
         e.bcyc  = (e.eat == 1) ? 3 : 2;
         gq.push_back(e);
      end
      frame_clk = 1'b1;
      cycles(3);
      frame_clk = 1'b0;
      if (in_g) begin
         wait_gq(30, "frame");
      end else begin
         cycles(8);
         chk("oog_score", int'(score), m_score);
         chk("oog_dots_left", int'(dots_left), m_dots);
      end
      cycles(3);
   endtask

   task automatic wait_busy(string name);
      int k = 0;
      @(negedge Clk);
      while (!busy && k < 20) begin
         @(negedge Clk);
         k++;
      end
      if (!busy) fail_now({name, "_busy_timeout"});
   endtask

   task automatic rand_pixel(output int x, output int y);
      if ($urandom_range(0, 5) == 0) begin
         x = $urandom_range(40, 400);
         y = $urandom_range(40, 400);
      end else begin
         x = OX + 8 * $urandom_range(0, GW - 1) + $urandom_range(2, 5);
         y = OY + 8 * $urandom_range(0, GH - 1) + $urandom_range(2, 5);
      end
   endtask

   initial begin
      int x, y, tr, tc;
      bit found;

      // Reset, pellet suppressed while refilling, full board afterwards
      do_reset();
      vdraw(59, 59, 1'b0);
      wait_gq(60, "clear");
      cycles(2);
      chk("level_clear_init", int'(level_clear), 0);
      vdraw_m(59, 59);
      vdraw_m(60, 60);
      vdraw_m(58, 59);
      cycles(3);

      // First eat and its effect on the picture; same cell again eats nothing
      frame(60, 60);
      vdraw_m(59, 59);
      vdraw_m(67, 59);
      cycles(3);
      frame(60, 60);

      // Grid edges: last cell eaten, one pixel outside either side ignored
      frame(391, 391);
      frame(392, 60);
      frame(55, 60);
      frame(60, 392);
      vdraw_m(388, 388);
      vdraw_m(380, 388);
      vdraw_m(392, 59);
      cycles(3);

      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            x = $urandom_range(0, 450);
            y = $urandom_range(0, 450);
         end else begin
            x = OX + 8 * $urandom_range(0, GW - 1) + $urandom_range(0, 7);
            y = OY + 8 * $urandom_range(0, GH - 1) + $urandom_range(0, 7);
         end
         frame(x, y);
         if (i % 4 == 0) begin
            for (int j = 0; j < 16; j++) begin
               rand_pixel(x, y);
               vdraw_m(x, y);
            end
            cycles(3);
         end
      end

      // Reset while the eat is in its write cycle
      found = 1'b0;
      tr = 0;
      tc = 0;
      for (int r = 0; r < GH; r++)
         for (int c = 0; c < GW; c++)
            if (!found && model_map[r][c]) begin
               found = 1'b1;
               tr = r;
               tc = c;
            end
      pacmanX = 10'(OX + 8 * tc + 1);
      pacmanY = 10'(OY + 8 * tr + 6);
      frame_clk = 1'b1;
      wait_busy("t5");
      frame_clk = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      chk("t5_score_before_write", int'(score), m_score);
      Reset_h = 1'b1;
      #1;
      chk("t5_score_async_reset", int'(score), 0);
      chk("t5_dots_async_reset", int'(dots_left), TOTAL);
      do_reset();
      wait_gq(60, "t5_clear");
      cycles(2);
      vdraw_m(OX + 8 * tc + 3, OY + 8 * tr + 4);
      vdraw_m(59, 59);
      cycles(3);

      // Video read of the row being written sees the pellet already gone
      begin
         gexp_t e;
         model_map[5][7] = 1'b0;
         m_score++;
         m_dots--;
         e.eat = 1; e.score = m_score; e.dots = m_dots; e.bcyc = 3;
         gq.push_back(e);
      end
      pacmanX = 10'(OX + 8 * 7 + 2);
      pacmanY = 10'(OY + 8 * 5 + 2);
      frame_clk = 1'b1;
      wait_busy("bypass");
      DrawX = 10'(OX + 8 * 7 + 3);
      DrawY = 10'(OY + 8 * 5 + 4);
      frame_clk = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      chk("bypass_before_write", int'(dot_on), 1);
      @(negedge Clk);
      chk("bypass_same_cycle", int'(dot_on), 0);
      cycles(1);
      wait_gq(10, "bypass");
      cycles(3);

      // Sweep every cell until the level is cleared
      for (int r = 0; r < GH; r++)
         for (int c = 0; c < GW; c++)
            frame(OX + 8 * c + $urandom_range(0, 7), OY + 8 * r + $urandom_range(0, 7));
      cycles(2);
      chk("final_score", int'(score), TOTAL);
      chk("final_dots_left", int'(dots_left), 0);
      chk("level_clear", int'(level_clear), 1);
      for (int i = 0; i < 3; i++)
         frame(OX + $urandom_range(0, XMAX - OX), OY + $urandom_range(0, YMAX - OY));
      for (int j = 0; j < 20; j++) begin
         rand_pixel(x, y);
         vdraw_m(x, y);
      end
      cycles(3);
      chk("level_clear_sticky", int'(level_clear), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
